fp_compare_pipe: RTL and testbench

FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fp_classify.sv | 21 ++
 rtl/fp_compare_pipe.sv | 135 +++++++++++++
 tb/tb_fp_compare_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: binary32 field widths, compare opcodes, operand class
// bits, and the registered result bundle of the compare pipeline.
package fpu_pkg;

  localparam int FLEN   = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  typedef enum logic [2:0] {
    FLT  = 3'd0,
    FEQ  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_e;

  typedef struct packed {
    logic zero;
    logic qnan;
    logic snan;
    logic sign;
  } fp_class_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
    logic nan;
    logic invalid;
    logic flt;
    logic feq;
    logic fle;
    logic fmin;
    logic fmax;
  } fcmp_res_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 classifier: zero, quiet/signalling NaN and sign.
module fp_classify
  import fpu_pkg::*;
(
  input  logic [FLEN-1:0] operand_i,
  output fp_class_t       class_o
);

  logic [EXP_W-1:0]  expField;
  logic [MANT_W-1:0] mantField;

  assign expField  = operand_i[FLEN-2 -: EXP_W];
  assign mantField = operand_i[MANT_W-1:0];

  // The mantissa MSB is the quiet bit; an all-ones exponent with zero mantissa is infinity.
  assign class_o.zero = (expField == '0) && (mantField == '0);
  assign class_o.qnan = (&expField) && mantField[MANT_W-1];
  assign class_o.snan = (&expField) && !mantField[MANT_W-1] && (|mantField);
  assign class_o.sign = operand_i[FLEN-1];

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage binary32 compare: S1 classifies and compares magnitudes,
// S2 resolves sign ordering and holds the result under backpressure.
module fp_compare_pipe
  import fpu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [FLEN-1:0] i_rs1_f,
  input  logic [FLEN-1:0] i_rs2_f,
  input  logic [2:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [FLEN-1:0] o_rs1_f,
  output logic [FLEN-1:0] o_rs2_f,
  output logic            o_flt,
  output logic            o_feq,
  output logic            o_fle,
  output logic            o_fmin,
  output logic            o_fmax,
  output logic            o_greater_than,
  output logic            o_less_than,
  output logic            o_equal,
  output logic            o_nan,
  output logic            o_invalid
);

  logic            s1_valid_q;
  logic [FLEN-1:0] s1_rs1_q, s1_rs2_q;
  logic [2:0]      s1_op_q;
  fp_class_t       s1_cls1_q, s1_cls2_q;
  logic            s1_mag_lt_q, s1_mag_eq_q;

  logic            s2_valid_q;
  logic [FLEN-1:0] s2_rs1_q, s2_rs2_q;
  fcmp_res_t       res_d, res_q;

  fp_class_t       cls1_d, cls2_d;
  logic            s2Advance;
  logic            anyNan, anySnan, bothZero;

  fp_classify u_cls_rs1 (.operand_i(i_rs1_f), .class_o(cls1_d));
  fp_classify u_cls_rs2 (.operand_i(i_rs2_f), .class_o(cls2_d));

  assign s2Advance = !s2_valid_q || i_ready;
  assign o_ready   = !s1_valid_q || s2Advance;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      s1_valid_q <= 1'b0;
    end else if (o_ready) begin
      s1_valid_q <= i_valid;
    end
  end

  // Payload needs no reset: it is only observed through s1_valid_q.
  always_ff @(posedge i_clk) begin
    if (i_valid && o_ready) begin
      s1_rs1_q    <= i_rs1_f;
      s1_rs2_q    <= i_rs2_f;
      s1_op_q     <= i_op;
      s1_cls1_q   <= cls1_d;
      s1_cls2_q   <= cls2_d;
      s1_mag_lt_q <= i_rs1_f[FLEN-2:0] <  i_rs2_f[FLEN-2:0];
      s1_mag_eq_q <= i_rs1_f[FLEN-2:0] == i_rs2_f[FLEN-2:0];
    end
  end

  assign anySnan  = s1_cls1_q.snan | s1_cls2_q.snan;
  assign anyNan   = anySnan | s1_cls1_q.qnan | s1_cls2_q.qnan;
  assign bothZero = s1_cls1_q.zero & s1_cls2_q.zero;

  always_comb begin
    res_d     = '0;
    res_d.nan = anyNan;
    if (!anyNan) begin
      if ((s1_rs1_q == s1_rs2_q) || bothZero) begin
        res_d.eq = 1'b1;
      end else if (s1_cls1_q.sign != s1_cls2_q.sign) begin
        res_d.lt = s1_cls1_q.sign;
        res_d.gt = s1_cls2_q.sign;
      end else if (!s1_cls1_q.sign) begin
        res_d.lt = s1_mag_lt_q;
        res_d.gt = !s1_mag_lt_q && !s1_mag_eq_q;
      end else begin
        res_d.lt = !s1_mag_lt_q && !s1_mag_eq_q;
        res_d.gt = s1_mag_lt_q;
      end
    end
    // Ordered compares signal on any NaN; equality and min/max only on signalling NaN.
    case (s1_op_q)
      FLT:     begin res_d.flt  = 1'b1; res_d.invalid = anyNan;  end
      FEQ:     begin res_d.feq  = 1'b1; res_d.invalid = anySnan; end
      FLE:     begin res_d.fle  = 1'b1; res_d.invalid = anyNan;  end
      FMIN:    begin res_d.fmin = 1'b1; res_d.invalid = anySnan; end
      FMAX:    begin res_d.fmax = 1'b1; res_d.invalid = anySnan; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid_q <= 1'b0;
      s2_rs1_q   <= '0;
      s2_rs2_q   <= '0;
      res_q      <= '0;
    end else if (i_flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2Advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_rs1_q <= s1_rs1_q;
        s2_rs2_q <= s1_rs2_q;
        res_q    <= res_d;
      end
    end
  end

  assign o_valid        = s2_valid_q;
  assign o_rs1_f        = s2_rs1_q;
  assign o_rs2_f        = s2_rs2_q;
  assign o_greater_than = res_q.gt;
  assign o_less_than    = res_q.lt;
  assign o_equal        = res_q.eq;
  assign o_nan          = res_q.nan;
  assign o_invalid      = res_q.invalid;
  assign o_flt          = res_q.flt;
  assign o_feq          = res_q.feq;
  assign o_fle          = res_q.fle;
  assign o_fmin         = res_q.fmin;
  assign o_fmax         = res_q.fmax;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe with hand-computed expected flags.
module tb_fp_compare_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready;
  logic [31:0] i_rs1_f, i_rs2_f;
  logic [2:0]  i_op;
  logic        o_ready, o_valid;
  logic [31:0] o_rs1_f, o_rs2_f;
  logic        o_flt, o_feq, o_fle, o_fmin, o_fmax;
  logic        o_greater_than, o_less_than, o_equal, o_nan, o_invalid;

  logic [4:0] flagsObs, decObs;
  assign flagsObs = {o_greater_than, o_less_than, o_equal, o_nan, o_invalid};
  assign decObs   = {o_flt, o_feq, o_fle, o_fmin, o_fmax};

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] burstA [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [4:0]  burstF [4] = '{5'b01000, 5'b00100, 5'b10000, 5'b10000};
  logic [31:0] gotRs1 [4];
  logic [4:0]  gotFlags [4];

  always #5 i_clk = ~i_clk;

  fp_compare_pipe dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_rs1_f(i_rs1_f), .i_rs2_f(i_rs2_f), .i_op(i_op),
    .o_valid(o_valid), .i_ready(i_ready), .o_rs1_f(o_rs1_f), .o_rs2_f(o_rs2_f),
    .o_flt(o_flt), .o_feq(o_feq), .o_fle(o_fle), .o_fmin(o_fmin), .o_fmax(o_fmax),
    .o_greater_than(o_greater_than), .o_less_than(o_less_than), .o_equal(o_equal),
    .o_nan(o_nan), .o_invalid(o_invalid)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [4:0] expFlags, input logic [4:0] expDec);
    i_rs1_f = a; i_rs2_f = b; i_op = op; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    #1;
    checkOutput({tag, " not yet valid"}, 32'(o_valid), 32'd0);
    tick();
    checkOutput({tag, " valid"}, 32'(o_valid), 32'd1);
    checkOutput({tag, " flags"}, 32'(flagsObs), 32'(expFlags));
    checkOutput({tag, " decode"}, 32'(decObs), 32'(expDec));
    checkOutput({tag, " rs1"}, o_rs1_f, a);
    tick();
  endtask

  initial begin
    int sent, got, stale;
    logic acc;
    i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_rs1_f = '0; i_rs2_f = '0; i_op = '0;
    tick(); tick();
    checkOutput("reset valid", 32'(o_valid), 32'd0);
    checkOutput("reset flags", 32'(flagsObs), 32'd0);
    checkOutput("reset decode", 32'(decObs), 32'd0);
    checkOutput("reset rs1", o_rs1_f, 32'd0);
    i_reset = 1'b0;
    #1;
    checkOutput("ready after reset", 32'(o_ready), 32'd1);
    tick();

    // flags = {gt, lt, eq, nan, invalid}; decode = {flt, feq, fle, fmin, fmax}
    applyStimulus("1.0<2.0 FLT",    32'h3F800000, 32'h40000000, 3'd0, 5'b01000, 5'b10000);
    applyStimulus("+0==-0 FEQ",     32'h00000000, 32'h80000000, 3'd1, 5'b00100, 5'b01000);
    applyStimulus("-1 vs -2 FLE",   32'hBF800000, 32'hC0000000, 3'd2, 5'b10000, 5'b00100);
    applyStimulus("qNaN FEQ",       32'h7FC00000, 32'h3F800000, 3'd1, 5'b00010, 5'b01000);
    applyStimulus("qNaN FLT",       32'h7FC00000, 32'h3F800000, 3'd0, 5'b00011, 5'b10000);
    applyStimulus("sNaN FEQ",       32'h7F800001, 32'h3F800000, 3'd1, 5'b00011, 5'b01000);
    applyStimulus("sNaN bad op",    32'h7F800001, 32'h3F800000, 3'd5, 5'b00010, 5'b00000);
    applyStimulus("2.0 vs 1.0 FMAX", 32'h40000000, 32'h3F800000, 3'd4, 5'b10000, 5'b00001);
    applyStimulus("-1 vs +1 FMIN",  32'hBF800000, 32'h3F800000, 3'd3, 5'b01000, 5'b00010);

    // Back-to-back burst with three stalled cycles on the result side
    i_ready = 1'b0; i_valid = 1'b1; i_rs2_f = 32'h40000000; i_op = 3'd0;
    i_rs1_f = burstA[0];
    #1;
    checkOutput("burst ready empty", 32'(o_ready), 32'd1);
    tick();
    i_rs1_f = burstA[1];
    #1;
    checkOutput("burst ready s2 empty", 32'(o_ready), 32'd1);
    tick();
    i_rs1_f = burstA[2];
    #1;
    checkOutput("burst ready full", 32'(o_ready), 32'd0);
    checkOutput("burst stall valid", 32'(o_valid), 32'd1);
    checkOutput("burst stall rs1", o_rs1_f, burstA[0]);
    tick();
    #1;
    checkOutput("burst hold ready", 32'(o_ready), 32'd0);
    checkOutput("burst hold rs1", o_rs1_f, burstA[0]);
    checkOutput("burst hold flags", 32'(flagsObs), 32'(burstF[0]));
    tick();
    i_ready = 1'b1;
    sent = 2; got = 0;
    for (int c = 0; c < 12; c++) begin
      i_valid = (sent < 4);
      i_rs1_f = burstA[(sent < 4) ? sent : 0];
      #1;
      if (o_valid) begin
        if (got < 4) begin
          gotRs1[got] = o_rs1_f;
          gotFlags[got] = flagsObs;
        end
        got++;
      end
      acc = i_valid && o_ready;
      tick();
      if (acc) sent++;
    end
    i_valid = 1'b0;
    checkOutput("burst sent", 32'(sent), 32'd4);
    checkOutput("burst delivered", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("burst rs1[%0d]", k), gotRs1[k], burstA[k]);
      checkOutput($sformatf("burst flags[%0d]", k), 32'(gotFlags[k]), 32'(burstF[k]));
    end

    // Flush with both stages full, plus a request in the flush cycle
    i_ready = 1'b0; i_valid = 1'b1; i_rs1_f = 32'h3F800000;
    tick(); tick();
    i_flush = 1'b1; i_rs1_f = 32'h40800000;
    #1;
    checkOutput("pre-flush valid", 32'(o_valid), 32'd1);
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    #1;
    checkOutput("flush valid", 32'(o_valid), 32'd0);
    checkOutput("flush ready", 32'(o_ready), 32'd1);
    stale = 0;
    repeat (5) begin
      if (o_valid) stale++;
      tick();
    end
    checkOutput("flush stale", 32'(stale), 32'd0);

    // Reset in the middle of a stream
    i_valid = 1'b1; i_rs1_f = 32'hBF800000; i_rs2_f = 32'h3F800000; i_op = 3'd2;
    tick(); tick();
    i_reset = 1'b1;
    tick();
    checkOutput("midreset valid", 32'(o_valid), 32'd0);
    checkOutput("midreset flags", 32'(flagsObs), 32'd0);
    checkOutput("midreset decode", 32'(decObs), 32'd0);
    checkOutput("midreset rs1", o_rs1_f, 32'd0);
    checkOutput("midreset rs2", o_rs2_f, 32'd0);
    i_reset = 1'b0; i_valid = 1'b0;
    #1;
    checkOutput("midreset ready", 32'(o_ready), 32'd1);
    tick(); tick();
    checkOutput("midreset no result", 32'(o_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
